// File: rtl/ex_mem_stage_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_mem_stage_reg_if                                       |
// | Brief    : EX->MEM stage bus: hazard controls, E-side inputs, M-side |
// |            registered outputs and bubble counter.                    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface ex_mem_stage_reg_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
);
   logic              stall;
   logic              flush;
   logic [DATA_W-1:0] alu_result_e;
   logic              zero_e;
   logic [DATA_W-1:0] write_data_e;
   logic [REG_W-1:0]  write_reg_e;
   logic [DATA_W-1:0] branch_target_e;
   logic              reg_write_e;
   logic              mem_read_e;
   logic              mem_write_e;
   logic              mem_to_reg_e;
   logic [2:0]        branch_type_e;

   logic [DATA_W-1:0] alu_result_m;
   logic [DATA_W-1:0] write_data_m;
   logic [REG_W-1:0]  write_reg_m;
   logic              reg_write_m;
   logic              mem_read_m;
   logic              mem_write_m;
   logic              mem_to_reg_m;
   logic              branch_taken_m;
   logic [DATA_W-1:0] branch_target_m;
   logic              valid_m;
   logic [CNT_W-1:0]  bubble_count;

   modport master (
      output stall, flush, alu_result_e, zero_e, write_data_e, write_reg_e,
             branch_target_e, reg_write_e, mem_read_e, mem_write_e,
             mem_to_reg_e, branch_type_e,
      input  alu_result_m, write_data_m, write_reg_m, reg_write_m, mem_read_m,
             mem_write_m, mem_to_reg_m, branch_taken_m, branch_target_m,
             valid_m, bubble_count
   );

   modport slave (
      input  stall, flush, alu_result_e, zero_e, write_data_e, write_reg_e,
             branch_target_e, reg_write_e, mem_read_e, mem_write_e,
             mem_to_reg_e, branch_type_e,
      output alu_result_m, write_data_m, write_reg_m, reg_write_m, mem_read_m,
             mem_write_m, mem_to_reg_m, branch_taken_m, branch_target_m,
             valid_m, bubble_count
   );
endinterface
`default_nettype wire

// File: rtl/ex_mem_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_mem_stage_reg                                          |
// | Brief    : EX->MEM pipeline register with branch resolution,         |
// |            stall/flush and a saturating bubble counter.              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module ex_mem_stage_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input wire logic           clk,
   input wire logic           rst,
   ex_mem_stage_reg_if.slave  bus
);
   localparam logic [2:0] c_BR_BEQ  = 3'd1;
   localparam logic [2:0] c_BR_BNE  = 3'd2;
   localparam logic [2:0] c_BR_BGTZ = 3'd3;
   localparam logic [2:0] c_BR_BLEZ = 3'd4;
   localparam logic [2:0] c_BR_BLTZ = 3'd5;
   localparam logic [2:0] c_BR_BGEZ = 3'd6;

   logic [DATA_W-1:0] r_alu_result;
   logic [DATA_W-1:0] r_write_data;
   logic [REG_W-1:0]  r_write_reg;
   logic              r_reg_write;
   logic              r_mem_read;
   logic              r_mem_write;
   logic              r_mem_to_reg;
   logic              r_branch_taken;
   logic [DATA_W-1:0] r_branch_target;
   logic              r_valid;
   logic [CNT_W-1:0]  r_bubble_count;

   logic              w_sign;
   logic              w_taken;

   assign w_sign = bus.alu_result_e[DATA_W-1];

   // Signed compares against zero rely on upstream feeding A-0 into the ALU.
   always_comb begin
      w_taken = 1'b0;
      case (bus.branch_type_e)
         c_BR_BEQ:  w_taken = bus.zero_e;
         c_BR_BNE:  w_taken = !bus.zero_e;
         c_BR_BGTZ: w_taken = !w_sign && !bus.zero_e;
         c_BR_BLEZ: w_taken = w_sign || bus.zero_e;
         c_BR_BLTZ: w_taken = w_sign;
         c_BR_BGEZ: w_taken = !w_sign;
         default:   w_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_result    <= '0;
         r_write_data    <= '0;
         r_write_reg     <= '0;
         r_reg_write     <= 1'b0;
         r_mem_read      <= 1'b0;
         r_mem_write     <= 1'b0;
         r_mem_to_reg    <= 1'b0;
         r_branch_taken  <= 1'b0;
         r_branch_target <= '0;
         r_valid         <= 1'b0;
         r_bubble_count  <= '0;
      end else if (bus.flush) begin
         r_alu_result    <= '0;
         r_write_data    <= '0;
         r_write_reg     <= '0;
         r_reg_write     <= 1'b0;
         r_mem_read      <= 1'b0;
         r_mem_write     <= 1'b0;
         r_mem_to_reg    <= 1'b0;
         r_branch_taken  <= 1'b0;
         r_branch_target <= '0;
         r_valid         <= 1'b0;
         if (r_bubble_count != {CNT_W{1'b1}})
            r_bubble_count <= r_bubble_count + 1'b1;
      end else if (!bus.stall) begin
         r_alu_result    <= bus.alu_result_e;
         r_write_data    <= bus.write_data_e;
         r_write_reg     <= bus.write_reg_e;
         r_reg_write     <= bus.reg_write_e;
         r_mem_read      <= bus.mem_read_e;
         r_mem_write     <= bus.mem_write_e;
         r_mem_to_reg    <= bus.mem_to_reg_e;
         r_branch_taken  <= w_taken;
         r_branch_target <= bus.branch_target_e;
         r_valid         <= 1'b1;
      end
   end

   assign bus.alu_result_m    = r_alu_result;
   assign bus.write_data_m    = r_write_data;
   assign bus.write_reg_m     = r_write_reg;
   assign bus.reg_write_m     = r_reg_write;
   assign bus.mem_read_m      = r_mem_read;
   assign bus.mem_write_m     = r_mem_write;
   assign bus.mem_to_reg_m    = r_mem_to_reg;
   assign bus.branch_taken_m  = r_branch_taken;
   assign bus.branch_target_m = r_branch_target;
   assign bus.valid_m         = r_valid;
   assign bus.bubble_count    = r_bubble_count;
endmodule
`default_nettype wire

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
Execute-to-memory pipeline register. It sits directly downstream of ALU32Bit and captures that block's ALUResult and Zero, together with the EX-stage store data, destination register and control bits. It resolves conditional branches from the ALU flags and registers the taken/target pair for the fetch stage. It supports stall (hold) and flush (bubble insertion) from the hazard unit, and keeps a bubble counter for debug.

Parameters:
DATA_W, 32, width of ALU result, store data and branch target
REG_W, 5, width of destination register index
CNT_W, 16, width of the bubble counter (saturating)

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous, active-high reset
Stall  input  1  hold all M-stage registers this cycle
Flush  input  1  load a bubble this cycle
ALUResult_E  input  DATA_W  result from ALU32Bit
Zero_E  input  1  Zero flag from ALU32Bit
WriteData_E  input  DATA_W  rt value for stores
WriteReg_E  input  REG_W  destination register index
BranchTarget_E  input  DATA_W  PC+4+(imm<<2), computed in EX
RegWrite_E, MemRead_E, MemWrite_E, MemToReg_E  input  1 each  control bits
BranchType_E  input  3  0 none, 1 BEQ, 2 BNE, 3 BGTZ, 4 BLEZ, 5 BLTZ, 6 BGEZ, 7 reserved (treated as none)
ALUResult_M  output  DATA_W  registered ALU result (memory address or writeback value)
WriteData_M  output  DATA_W  registered store data
WriteReg_M  output  REG_W  registered destination index
RegWrite_M, MemRead_M, MemWrite_M, MemToReg_M  output  1 each  registered control bits
BranchTaken_M  output  1  registered branch decision
BranchTarget_M  output  DATA_W  registered target; valid when BranchTaken_M=1
Valid_M  output  1  1 = real instruction in M, 0 = bubble
BubbleCount  output  CNT_W  count of bubbles inserted by Flush

Behaviour:
- Reset (async, Rst=1): every output goes to 0 immediately, BubbleCount included. This state equals a bubble.
- Priority on each rising Clk when Rst=0: Flush > Stall > load.
- Load (Flush=0, Stall=0): every _E input is captured into its _M counterpart one cycle later; Valid_M<=1. Latency is exactly 1 cycle.
- Stall (Flush=0, Stall=1): all _M outputs, Valid_M and BubbleCount hold their values.
- Flush (Flush=1, Stall ignored):
  - RegWrite_M, MemRead_M, MemWrite_M, MemToReg_M, BranchTaken_M, Valid_M <= 0.
  - Data fields (ALUResult_M, WriteData_M, WriteReg_M, BranchTarget_M) <= 0.
  - BubbleCount increments by 1 and saturates at all-ones (no wrap).
- Branch decision, combinational from E inputs and registered on load:
  - BEQ: Zero_E. Upstream drives A-B into the ALU.
  - BNE: !Zero_E.
  - BGTZ: !ALUResult_E[DATA_W-1] && !Zero_E.
  - BLEZ: ALUResult_E[DATA_W-1] || Zero_E.
  - BLTZ: ALUResult_E[DATA_W-1].
  - BGEZ: !ALUResult_E[DATA_W-1].
  - For BGTZ/BLEZ/BLTZ/BGEZ, upstream drives A-0.
  - Types 0 and 7: not taken.
- BranchTaken_M pulses for one cycle per taken branch, unless the stage is stalled; a held instruction keeps it high. The fetch stage must treat it as level-sensitive together with Stall.
- Hazard contract: after a cycle with BranchTaken_M=1, the hazard unit asserts Flush to squash the wrong-path instruction. This block does not self-flush.
- Reset asserted mid-stall or mid-flush: outputs clear asynchronously. The first edge after release performs a normal load or flush.
- Simultaneous Stall and Flush: flush wins, and the counter increments.
- No combinational path from any input to any output.

Test Plan:
- Reset: Rst=1 with all inputs nonzero -> all outputs 0 before the next Clk edge; after release, one edge loads ALUResult_E=0x0000_0010 -> ALUResult_M=0x10, Valid_M=1.
- Branches:
  - BranchType=1, Zero_E=1, BranchTarget_E=0x40 -> next cycle BranchTaken_M=1, BranchTarget_M=0x40.
  - Same with Zero_E=0 -> BranchTaken_M=0.
  - BranchType=3, ALUResult_E=0xFFFF_FFFF -> taken=0; ALUResult_E=5 -> taken=1.
- Stall hold: load MemWrite=1, WriteData=0xDEAD_BEEF, then hold Stall=1 for 3 cycles while inputs change -> outputs unchanged for all 3 cycles; Stall=0 -> new inputs captured next edge.
- Flush priority: Stall=1 and Flush=1 together with RegWrite_E=1 -> RegWrite_M=0, Valid_M=0, BubbleCount 0->1.
- Saturation: CNT_W=2, apply 5 consecutive flushes -> BubbleCount sequence 1, 2, 3, 3, 3.
- Async reset mid-stream: assert Rst between clock edges while Valid_M=1 -> Valid_M and BubbleCount drop to 0 without waiting for a clock edge.
